// File: rtl/dbg_burst_regs_if.sv
// -----------------------------------------------------------------------------
// dbg_burst_regs_if
// Debug-host register bus shared by the debug host (master) and
// dbg_burst_regs (slave).
//   dbg_a     : register address (8 bit)
//   dbg_di    : write data (16 bit)
//   dbg_do    : read data (16 bit), zero whenever dbg_rd is low
//   dbg_we    : write strobe
//   dbg_rd    : read strobe
//   dbg_ready : access completes in the cycle it is high
// -----------------------------------------------------------------------------
interface dbg_burst_regs_if;
   logic [7:0]  dbg_a;
   logic [15:0] dbg_di;
   logic [15:0] dbg_do;
   logic        dbg_we;
   logic        dbg_rd;
   logic        dbg_ready;

   modport master (output dbg_a, dbg_di, dbg_we, dbg_rd, input dbg_do, dbg_ready);
   modport slave  (input dbg_a, dbg_di, dbg_we, dbg_rd, output dbg_do, dbg_ready);
endinterface

// File: rtl/dbg_burst_regs.sv
// -----------------------------------------------------------------------------
// dbg_burst_regs
// Debug register block in front of a QSPI engine. It provides configuration
// registers, single-word accesses and a burst read prefetch into a small FIFO.
// Optional feature macro: DBG_BURST_CRC_EN adds a CRC-16-CCITT over the pushed
// words at register 0x18. When the macro is not defined, 0x18 reads 0.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   dbg                   : debug register bus (slave modport)
//   debug_addr_o          : QSPI byte address, advances by 2 per word
//   debug_rdata_i         : QSPI read word
//   debug_wdata_o/_wstrb_o: QSPI write word and byte strobes
//   debug_ready_i         : QSPI word done
//   debug_xfer_done_i     : QSPI transfer terminated early
//   debug_valid_o         : request towards the QSPI engine
//   debug_xfer_len_o      : number of words in the current request
//   debug_ce_ctrl_o, addr_16b_o, is_flash_o, quad_mode_o,
//   dummy_read_cycles_o, plus_guard_time_o : per-chip-select configuration
// -----------------------------------------------------------------------------
module dbg_burst_regs #(
   parameter int CHIP_SELECTS = 2,
   parameter int BURST_DEPTH  = 8,
   parameter int ADDR_W       = 24
) (
   input  logic                      clk,
   input  logic                      rst_n,
   dbg_burst_regs_if.slave           dbg,
   output logic [ADDR_W-1:0]         debug_addr_o,
   input  logic [15:0]               debug_rdata_i,
   output logic [15:0]               debug_wdata_o,
   output logic [1:0]                debug_wstrb_o,
   input  logic                      debug_ready_i,
   input  logic                      debug_xfer_done_i,
   output logic                      debug_valid_o,
   output logic [3:0]                debug_xfer_len_o,
   output logic [CHIP_SELECTS-1:0]   debug_ce_ctrl_o,
   output logic [CHIP_SELECTS-1:0]   addr_16b_o,
   output logic [CHIP_SELECTS-1:0]   is_flash_o,
   output logic [CHIP_SELECTS-1:0]   quad_mode_o,
   output logic [CHIP_SELECTS*4-1:0] dummy_read_cycles_o,
   output logic [3:0]                plus_guard_time_o
);
   localparam int CS    = CHIP_SELECTS;
   localparam int AHI_W = ADDR_W - 16;
   localparam int PTR_W = (BURST_DEPTH > 1) ? $clog2(BURST_DEPTH) : 1;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SINGLE = 2'd1, ST_BURST = 2'd2} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [CS-1:0]       ce_ctrl_q, addr_16b_q, is_flash_q, quad_mode_q;
   logic [CS*4-1:0]     dummy_q;
   logic [3:0]          guard_q, blen_q, cnt_q;
   logic                ovf_q, unf_q;
   logic [15:0]         mem_q [BURST_DEPTH];
   logic [PTR_W-1:0]    rd_q, wr_q;
   logic [4:0]          count_q;

   logic                acc_s, flush_s, xfer_ack_s, push_s, pop_s, busy_s;
   logic                single_go_s, burst_go_s, ovf_set_s, unf_set_s, space_ok_s;
   logic                rdy_s;
   logic [15:0]         rdata_s, status_s, crc_rd_s;
   logic [3:0]          blen_wr_s;

   assign acc_s      = dbg.dbg_rd | dbg.dbg_we;
   assign flush_s    = dbg.dbg_we && (dbg.dbg_a == 8'h23);
   assign xfer_ack_s = debug_ready_i && (state_q != ST_IDLE);
   // A flush aborts the burst, so a word arriving in the same cycle is dropped.
   assign push_s     = debug_ready_i && (state_q == ST_BURST) && !flush_s;
   assign space_ok_s = ((5'(BURST_DEPTH) - count_q) >= {1'b0, blen_q});
   assign status_s   = {busy_s, ovf_q, unf_q, 8'h00, count_q};
   assign blen_wr_s  = (dbg.dbg_di[3:0] == 4'd0) ? 4'd1 :
                       ({1'b0, dbg.dbg_di[3:0]} > 5'(BURST_DEPTH)) ? 4'(BURST_DEPTH) :
                       dbg.dbg_di[3:0];

   assign dbg.dbg_ready = rdy_s;
   assign dbg.dbg_do    = dbg.dbg_rd ? rdata_s : 16'h0000;

   assign debug_addr_o        = addr_q;
   assign debug_ce_ctrl_o     = ce_ctrl_q;
   assign addr_16b_o          = addr_16b_q;
   assign is_flash_o          = is_flash_q;
   assign quad_mode_o         = quad_mode_q;
   assign dummy_read_cycles_o = dummy_q;
   assign plus_guard_time_o   = guard_q;

`ifdef DBG_BURST_CRC_EN
   logic [15:0] crc_q;

   function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [15:0] d);
      logic [15:0] c;
      c = crc;
      for (int i = 15; i >= 0; i--) begin
         c = (c[15] ^ d[i]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
      end
      return c;
   endfunction

   // CRC over every pushed word, restarted by flush or reset
   always_ff @(posedge clk) begin
      if (!rst_n || flush_s) crc_q <= 16'hFFFF;
      else if (push_s)       crc_q <= crc16_word(crc_q, debug_rdata_i);
      else                   crc_q <= crc_q;
   end
   assign crc_rd_s = crc_q;
`else
   assign crc_rd_s = 16'h0000;
`endif

   // Register decode: read mux, ready and side-effect strobes
   always_comb begin
      rdy_s = 1'b0; rdata_s = 16'h0000; pop_s = 1'b0;
      single_go_s = 1'b0; burst_go_s = 1'b0; ovf_set_s = 1'b0; unf_set_s = 1'b0;
      if (acc_s) begin
         rdy_s = 1'b1;
         case (dbg.dbg_a)
            8'h10: rdata_s = addr_q[15:0];
            8'h11: rdata_s = 16'(addr_q[ADDR_W-1:16]);
            8'h12: rdata_s = 16'(ce_ctrl_q);
            8'h13: rdata_s = 16'({addr_16b_q, is_flash_q, quad_mode_q});
            8'h14: rdata_s = 16'(dummy_q);
            8'h15: rdata_s = {12'h000, guard_q};
            8'h16: rdata_s = {12'h000, blen_q};
            8'h17: rdata_s = status_s;
            8'h18: rdata_s = crc_rd_s;
            8'h20: begin
               // Completes only when the QSPI word handshake finishes in SINGLE.
               rdy_s = (state_q == ST_SINGLE) ? debug_ready_i : 1'b0;
               rdata_s = (state_q == ST_SINGLE) ? debug_rdata_i : 16'h0000;
               single_go_s = (state_q == ST_IDLE);
            end
            8'h21: begin
               if (state_q == ST_IDLE) begin
                  burst_go_s = dbg.dbg_we && space_ok_s;
                  ovf_set_s  = dbg.dbg_we && !space_ok_s;
               end else begin
                  rdy_s = 1'b0;
               end
            end
            8'h22: begin
               if (!dbg.dbg_rd) begin
                  rdy_s = 1'b1;
               end else if (count_q != 5'd0) begin
                  pop_s = 1'b1; rdata_s = mem_q[rd_q];
               end else if (state_q == ST_BURST) begin
                  // Empty during a burst: wait and bypass the arriving word.
                  rdy_s = push_s; pop_s = push_s; rdata_s = debug_rdata_i;
               end else begin
                  unf_set_s = 1'b1;
               end
            end
            default: rdata_s = 16'h0000;
         endcase
      end else begin
         rdy_s = 1'b0;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   state_d = single_go_s ? ST_SINGLE : (burst_go_s ? ST_BURST : ST_IDLE);
         ST_SINGLE: state_d = debug_ready_i ? ST_IDLE : ST_SINGLE;
         ST_BURST: begin
            if (flush_s || debug_xfer_done_i || (push_s && ((cnt_q + 4'd1) >= blen_q)))
               state_d = ST_IDLE;
            else
               state_d = ST_BURST;
         end
         default:   state_d = ST_IDLE;
      endcase
   end

   // FSM outputs towards the QSPI engine
   always_comb begin
      debug_valid_o = 1'b0; debug_xfer_len_o = 4'd0; debug_wdata_o = 16'h0000;
      debug_wstrb_o = 2'b00; busy_s = 1'b1;
      case (state_q)
         ST_IDLE: busy_s = 1'b0;
         ST_SINGLE: begin
            debug_valid_o = 1'b1; debug_xfer_len_o = 4'd1;
            debug_wdata_o = dbg.dbg_we ? dbg.dbg_di : 16'h0000;
            debug_wstrb_o = dbg.dbg_we ? 2'b11 : 2'b00;
         end
         ST_BURST: begin
            debug_valid_o = 1'b1; debug_xfer_len_o = blen_q;
         end
         default: busy_s = 1'b0;
      endcase
   end

   // Address and configuration registers, error flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q <= '0; ce_ctrl_q <= CS'(1); is_flash_q <= CS'(1); quad_mode_q <= CS'(1);
         addr_16b_q <= '0; dummy_q <= (CS*4)'(4'ha); guard_q <= 4'd1;
         blen_q <= 4'(BURST_DEPTH); ovf_q <= 1'b0; unf_q <= 1'b0;
      end else begin
         // The address only takes host writes while the FSM is idle.
         if (dbg.dbg_we && (dbg.dbg_a == 8'h10) && !busy_s)      addr_q[15:0] <= dbg.dbg_di;
         else if (dbg.dbg_we && (dbg.dbg_a == 8'h11) && !busy_s) addr_q[ADDR_W-1:16] <= dbg.dbg_di[AHI_W-1:0];
         else if (xfer_ack_s)                                    addr_q <= addr_q + ADDR_W'(2);
         else                                                    addr_q <= addr_q;
         if (dbg.dbg_we) begin
            case (dbg.dbg_a)
               8'h12:   ce_ctrl_q <= dbg.dbg_di[CS-1:0];
               8'h13:   {addr_16b_q, is_flash_q, quad_mode_q} <= dbg.dbg_di[3*CS-1:0];
               8'h14:   dummy_q <= dbg.dbg_di[4*CS-1:0];
               8'h15:   guard_q <= dbg.dbg_di[3:0];
               8'h16:   blen_q <= blen_wr_s;
               default: guard_q <= guard_q;
            endcase
         end
         ovf_q <= flush_s ? 1'b0 : (ovf_q | ovf_set_s);
         unf_q <= flush_s ? 1'b0 : (unf_q | unf_set_s);
      end
   end

   // Prefetch FIFO pointers, occupancy and burst word counter
   always_ff @(posedge clk) begin
      if (!rst_n || flush_s) begin
         rd_q <= '0; wr_q <= '0; count_q <= 5'd0; cnt_q <= 4'd0;
      end else begin
         rd_q    <= pop_s  ? rd_q + PTR_W'(1) : rd_q;
         wr_q    <= push_s ? wr_q + PTR_W'(1) : wr_q;
         count_q <= count_q + 5'(push_s) - 5'(pop_s);
         cnt_q   <= burst_go_s ? 4'd0 : (push_s ? cnt_q + 4'd1 : cnt_q);
      end
   end

   // FIFO storage (a bypassed word is written and consumed in the same cycle)
   always_ff @(posedge clk) begin
      if (push_s) mem_q[wr_q] <= debug_rdata_i;
   end
endmodule

// File: tb/tb_dbg_burst_regs.sv
// -----------------------------------------------------------------------------
// tb_dbg_burst_regs
// Directed self-checking bench for dbg_burst_regs with its default parameters
// (2 chip selects, 8-word FIFO, 24-bit address). Inputs change 1 ns after the
// rising edge, and outputs are sampled before the next edge.
// -----------------------------------------------------------------------------
module tb_dbg_burst_regs;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] debug_addr;
   logic [15:0] debug_rdata = 16'h0000;
   logic [15:0] debug_wdata;
   logic [1:0]  debug_wstrb;
   logic        debug_ready = 1'b0;
   logic        debug_xfer_done = 1'b0;
   logic        debug_valid;
   logic [3:0]  debug_xfer_len;
   logic [1:0]  ce_ctrl, addr_16b, is_flash, quad_mode;
   logic [7:0]  dummy;
   logic [3:0]  guard;
   int          n_cmp = 0;
   int          n_err = 0;

   dbg_burst_regs_if bus ();

   dbg_burst_regs dut (
      .clk(clk), .rst_n(rst_n), .dbg(bus),
      .debug_addr_o(debug_addr), .debug_rdata_i(debug_rdata),
      .debug_wdata_o(debug_wdata), .debug_wstrb_o(debug_wstrb),
      .debug_ready_i(debug_ready), .debug_xfer_done_i(debug_xfer_done),
      .debug_valid_o(debug_valid), .debug_xfer_len_o(debug_xfer_len),
      .debug_ce_ctrl_o(ce_ctrl), .addr_16b_o(addr_16b), .is_flash_o(is_flash),
      .quad_mode_o(quad_mode), .dummy_read_cycles_o(dummy), .plus_guard_time_o(guard)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic reg_wr(input logic [7:0] a, input logic [15:0] d, input string tag);
      bus.dbg_a = a; bus.dbg_di = d; bus.dbg_we = 1'b1; #1;
      check_eq(tag, {31'd0, bus.dbg_ready}, 32'd1);
      tick();
      bus.dbg_we = 1'b0;
   endtask

   task automatic reg_rd(input logic [7:0] a, input logic [15:0] exp, input string tag);
      bus.dbg_a = a; bus.dbg_rd = 1'b1; #1;
      check_eq(tag, {15'd0, bus.dbg_ready, bus.dbg_do}, {15'd0, 1'b1, exp});
      tick();
      bus.dbg_rd = 1'b0;
   endtask

   task automatic push_words(input int n, input logic [15:0] base);
      for (int i = 0; i < n; i++) begin
         debug_ready = 1'b1; debug_rdata = base + 16'(i);
         tick();
      end
      debug_ready = 1'b0;
   endtask

   initial begin
      logic [15:0] crc_exp;
      bus.dbg_a = 8'h00; bus.dbg_di = 16'h0000; bus.dbg_we = 1'b0; bus.dbg_rd = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Reset state
      check_eq("rst_valid_addr", {7'd0, debug_valid, debug_addr}, 32'h0);
      check_eq("rst_cfg", {ce_ctrl, quad_mode, is_flash, addr_16b}, 32'b01_01_01_00);
      check_eq("rst_dummy_guard", {dummy, guard}, 32'h0a1);
      reg_rd(8'h16, 16'h0008, "rst_burst_len");
      reg_rd(8'h17, 16'h0000, "rst_status");
      reg_rd(8'h30, 16'h0000, "unmapped_rd");

      // Single read at 0x561234
      reg_wr(8'h10, 16'h1234, "wr_addr_lo");
      reg_wr(8'h11, 16'h0056, "wr_addr_hi");
      check_eq("addr_out", {8'd0, debug_addr}, 32'h561234);
      bus.dbg_a = 8'h20; bus.dbg_rd = 1'b1; #1;
      check_eq("single_idle_rdy", {31'd0, bus.dbg_ready}, 32'd0);
      tick();
      check_eq("single_req", {debug_valid, debug_xfer_len, debug_wstrb, bus.dbg_ready}, {1'b1, 4'd1, 2'b00, 1'b0});
      debug_ready = 1'b1; debug_rdata = 16'hBEEF; #1;
      check_eq("single_rd_data", {15'd0, bus.dbg_ready, bus.dbg_do}, {15'd0, 1'b1, 16'hBEEF});
      tick();
      bus.dbg_rd = 1'b0; debug_ready = 1'b0;
      check_eq("single_done_valid", {31'd0, debug_valid}, 32'd0);
      reg_rd(8'h10, 16'h1236, "addr_after_rd");

      // Single write
      bus.dbg_a = 8'h20; bus.dbg_di = 16'hCAFE; bus.dbg_we = 1'b1;
      tick();
      check_eq("single_wr_req", {debug_wstrb, debug_wdata}, {2'b11, 16'hCAFE});
      debug_ready = 1'b1; tick();
      bus.dbg_we = 1'b0; debug_ready = 1'b0;
      check_eq("addr_after_wr", {8'd0, debug_addr}, 32'h561238);

      // Burst of 4 and drain
      reg_wr(8'h16, 16'h000F, "wr_blen_big");
      reg_rd(8'h16, 16'h0008, "blen_clamp_hi");
      reg_wr(8'h16, 16'h0004, "wr_blen4");
      reg_wr(8'h21, 16'h0000, "start_burst4");
      check_eq("burst4_req", {debug_valid, debug_xfer_len}, {1'b1, 4'd4});
      push_words(4, 16'h00A0);
      check_eq("burst4_end_valid", {31'd0, debug_valid}, 32'd0);
      reg_rd(8'h17, 16'h0004, "status_cnt4");
      for (int i = 0; i < 4; i++) reg_rd(8'h22, 16'h00A0 + 16'(i), "pop_burst4");
      reg_rd(8'h17, 16'h0000, "status_drained");
      check_eq("addr_after_burst", {8'd0, debug_addr}, 32'h561240);

      // Overflow: 6 words held, then a 4-word request does not fit
      reg_wr(8'h16, 16'h0006, "wr_blen6");
      reg_wr(8'h21, 16'h0000, "start_burst6");
      reg_wr(8'h10, 16'hFFFF, "wr_addr_busy");
      push_words(6, 16'h0100);
      check_eq("addr_busy_ignored", {8'd0, debug_addr}, 32'h56124C);
      reg_wr(8'h16, 16'h0004, "wr_blen4b");
      reg_wr(8'h21, 16'h0000, "start_ovf");
      check_eq("ovf_no_valid", {31'd0, debug_valid}, 32'd0);
      reg_rd(8'h17, 16'h4006, "status_ovf");
      reg_wr(8'h23, 16'h0000, "flush1");
      reg_rd(8'h17, 16'h0000, "status_flushed");

      // Empty read during a burst waits, then bypasses
      reg_wr(8'h16, 16'h0002, "wr_blen2");
      reg_wr(8'h21, 16'h0000, "start_burst2");
      bus.dbg_a = 8'h22; bus.dbg_rd = 1'b1; #1;
      check_eq("bypass_wait0", {31'd0, bus.dbg_ready}, 32'd0);
      tick();
      check_eq("bypass_wait1", {31'd0, bus.dbg_ready}, 32'd0);
      debug_ready = 1'b1; debug_rdata = 16'h1111; #1;
      check_eq("bypass_data", {15'd0, bus.dbg_ready, bus.dbg_do}, {15'd0, 1'b1, 16'h1111});
      tick();
      bus.dbg_rd = 1'b0; debug_rdata = 16'h2222;
      tick();
      debug_ready = 1'b0;
      reg_rd(8'h17, 16'h0001, "status_after_bypass");
      reg_rd(8'h22, 16'h2222, "pop_second");
      reg_rd(8'h22, 16'h0000, "idle_empty_rd");
      reg_rd(8'h17, 16'h2000, "status_unf");

      // Early termination and flush abort
      reg_wr(8'h16, 16'h0004, "wr_blen4c");
      reg_wr(8'h21, 16'h0000, "start_done");
      push_words(1, 16'h0333);
      debug_xfer_done = 1'b1; tick(); debug_xfer_done = 1'b0;
      check_eq("xfer_done_valid", {31'd0, debug_valid}, 32'd0);
      reg_rd(8'h17, 16'h2001, "status_xfer_done");
      reg_wr(8'h21, 16'h0000, "start_abort");
      reg_wr(8'h23, 16'h0000, "flush_abort");
      check_eq("abort_valid", {31'd0, debug_valid}, 32'd0);
      reg_rd(8'h17, 16'h0000, "status_abort");

      // Reset in the middle of a burst
      reg_wr(8'h21, 16'h0000, "start_rst");
      push_words(2, 16'h0400);
      rst_n = 1'b0; tick();
      check_eq("rst_mid_burst", {7'd0, debug_valid, debug_addr}, 32'h0);
      rst_n = 1'b1; tick();
      reg_rd(8'h17, 16'h0000, "status_after_rst");
      reg_wr(8'h16, 16'h0000, "wr_blen0");
      reg_rd(8'h16, 16'h0001, "blen_clamp_lo");

      // CRC register over one pushed zero word
      reg_wr(8'h21, 16'h0000, "start_crc");
      push_words(1, 16'h0000);
`ifdef DBG_BURST_CRC_EN
      crc_exp = 16'h1D0F;
`else
      crc_exp = 16'h0000;
`endif
      reg_rd(8'h18, crc_exp, "crc_reg");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/dbg_burst_regs.md
DBG_BURST_REGS -- requirements
Module: dbg_burst_regs

Interface
REQ-001 SHALL have parameter CHIP_SELECTS, default 2, meaning the number of QSPI chip selects (1..4).
REQ-002 SHALL have parameter BURST_DEPTH, default 8, meaning the read-prefetch FIFO depth in 16-bit words (2, 4 or 8).
REQ-003 SHALL have parameter ADDR_W, default 24, meaning the QSPI byte-address width (17..32).
REQ-004 SHALL have ports clk in 1 (clock); rst_n in 1 (reset: synchronous, active-low).
REQ-005 SHALL have debug-side ports: dbg_a in 8; dbg_di in 16; dbg_do out 16; dbg_we in 1; dbg_rd in 1; dbg_ready out 1.
REQ-006 SHALL have QSPI-side ports: debug_addr out ADDR_W; debug_rdata in 16; debug_wdata out 16; debug_wstrb out 2; debug_ready in 1 (word done); debug_xfer_done in 1; debug_valid out 1; debug_xfer_len out 4.
REQ-007 SHALL have config outputs: debug_ce_ctrl, addr_16b, is_flash, quad_mode, each CHIP_SELECTS wide; dummy_read_cycles out CHIP_SELECTS*4; plus_guard_time out 4.

Function
REQ-008 Register map SHALL be (R/W unless noted):
- 0x10 addr[15:0]; 0x11 addr[ADDR_W-1:16]; 0x12 ce_ctrl; 0x13 {addr_16b,is_flash,quad_mode}; 0x14 dummy_read_cycles; 0x15 plus_guard_time.
- 0x16 burst_len[3:0].
- 0x17 status, RO: {busy[15], ovf_err[14], unf_err[13], 8'b0, fifo_count[4:0]}.
- Unmapped addresses read 0 and ignore writes.
REQ-009 Register reads/writes in 0x1x SHALL complete with dbg_ready=1 combinationally in the same cycle as dbg_rd|dbg_we; dbg_do SHALL be 0 whenever dbg_rd=0.
REQ-010 burst_len writes SHALL clamp: 0 stores 1; values >BURST_DEPTH store BURST_DEPTH.
REQ-011 FSM states SHALL be IDLE, SINGLE and BURST; busy=1 in every state except IDLE.
REQ-012 Address 0x20 (single-word access) behaviour:
- In IDLE, rd or we SHALL enter SINGLE.
- In SINGLE: debug_valid=1 until debug_ready; debug_xfer_len=1; debug_wdata=dbg_di on write, else 0; debug_wstrb=2'b11 on write, else 0.
- dbg_ready SHALL equal debug_ready, and dbg_do SHALL equal debug_rdata.
- On debug_ready: debug_addr += 2 (mod 2^ADDR_W), return to IDLE.
REQ-013 A write to 0x21 in IDLE SHALL start a prefetch:
- If free FIFO space >= burst_len: enter BURST.
- Otherwise: set ovf_err, stay IDLE.
- In both cases dbg_ready=1 that cycle.
REQ-014 In BURST:
- debug_valid=1; debug_xfer_len=burst_len.
- Each debug_ready SHALL push debug_rdata and add 2 to debug_addr.
- After the burst_len-th push, or on debug_xfer_done, SHALL go to IDLE with debug_valid=0 in the next cycle.
REQ-015 A read of 0x22 SHALL pop the FIFO head onto dbg_do with dbg_ready=1 in the same cycle when the FIFO is non-empty.
- If empty in BURST: hold dbg_ready=0 until a word arrives; that word SHALL be forwarded to dbg_do the same cycle as its push (bypass).
- If empty in IDLE: dbg_ready=1, dbg_do=0, set unf_err.
REQ-016 Push and pop in the same cycle SHALL leave fifo_count unchanged; the FIFO SHALL never overflow (guaranteed by REQ-013).
REQ-017 A write to 0x23 SHALL flush the FIFO and clear ovf_err/unf_err.
- In BURST, the flush SHALL also abort the burst: return to IDLE, debug_valid=0 next cycle.
REQ-018 Accesses to 0x20/0x21 while not in IDLE SHALL hold dbg_ready=0 until the FSM returns to IDLE and the access completes.
REQ-019 Writes to 0x10/0x11 while busy SHALL be ignored, with dbg_ready=1.

Reset
REQ-020 Synchronous reset SHALL set:
- FSM=IDLE; FIFO empty; flags 0; debug_valid=0; debug_addr=0.
- debug_ce_ctrl, quad_mode, is_flash = 1 (LSB only); addr_16b=0.
- dummy_read_cycles = 4'ha in the low nibble, 0 elsewhere.
- plus_guard_time=1; burst_len=BURST_DEPTH.
REQ-021 Reset asserted mid-burst SHALL deassert debug_valid in the cycle after the reset clock edge, discarding all words.

Configuration
REQ-022 Macro DBG_BURST_CRC_EN defined:
- 0x18 (RO) SHALL return CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first) over every word pushed since the last 0x23 write or reset.
- The CRC SHALL update in the push cycle.
REQ-023 Macro DBG_BURST_CRC_EN undefined: no CRC logic; 0x18 SHALL read 0.

Verification
REQ-024 Write 0x10=0x1234, 0x11=0x0056, then single read 0x20 with debug_rdata=0xBEEF -> dbg_do=0xBEEF while debug_ready=1; 0x10 then reads 0x1236.
REQ-025 burst_len=4, write 0x21, rdata 0xA0..0xA3 -> debug_xfer_len=4, status fifo_count=4, four 0x22 reads return 0xA0..0xA3, fifo_count=0.
REQ-026 FIFO holding 6 words (BURST_DEPTH=8), burst_len=4, write 0x21 -> no debug_valid, status bit14=1; write 0x23 -> status=0x0000.
REQ-027 Read 0x22 on an empty FIFO during BURST -> dbg_ready=0 until the first debug_ready, then dbg_do equals that rdata in the same cycle; idle empty read -> dbg_do=0, status bit13=1.
REQ-028 Assert rst_n=0 after 2 of 4 burst words -> debug_valid=0 next cycle, status=0, debug_addr=0; write 0x16=0 -> reads 1.
REQ-029 With DBG_BURST_CRC_EN: single pushed word 0x0000 -> 0x18 reads 0x1D0F; without the macro -> 0x18 reads 0.
